button_event_scheduler: RTL and testbench

BUTTON_EVENT_SCHEDULER -- requirements
Module: button_event_scheduler

---
 rtl/button_event_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_button_event_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : button_event_scheduler
// Brief   : Collects per-button press/release strobes into single-entry slots,
//           round-robin arbitrates them into a small event FIFO.
//           Optional auto-repeat generator enabled by macro BTN_AUTOREPEAT_EN.
// Rev     : 1.0
// ============================================================================
module button_event_scheduler #(
    parameter int          N         = 4,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] RPT_DELAY = 16'd50000,
    parameter logic [15:0] RPT_RATE  = 16'd10000
) (
    input  logic                      CLK,
    input  logic                      nRESET,
    input  logic [N-1:0]              DOWN,
    input  logic [N-1:0]              UP,
    input  logic [N-1:0]              STATE,
    output logic                      EV_VALID,
    output logic [1:0]                EV_KIND,
    output logic [$clog2(N)-1:0]      EV_ID,
    input  logic                      EV_ACK,
    output logic                      OVF,
    input  logic                      OVF_CLR,
    output logic [$clog2(DEPTH):0]    COUNT
);
    localparam int          LN        = $clog2(N);
    localparam int          LD        = $clog2(DEPTH);
    localparam logic [LD:0] C_DEPTH   = (LD+1)'(DEPTH);
    localparam logic [1:0]  KIND_DOWN = 2'b00;
    localparam logic [1:0]  KIND_UP   = 2'b01;
    localparam logic [1:0]  KIND_RPT  = 2'b10;

    logic [N-1:0]             slot_v_q, slot_v_d;
    logic [N-1:0][1:0]        slot_kind_q, slot_kind_d;
    logic [LN-1:0]            arb_ptr_q, arb_ptr_d;
    logic [DEPTH-1:0][1:0]    fifo_kind_q;
    logic [DEPTH-1:0][LN-1:0] fifo_id_q;
    logic [LD-1:0]            wr_ptr_q, rd_ptr_q;
    logic [LD:0]              count_q, count_d;
    logic                     ev_valid_q;
    logic                     ovf_q, ovf_d;
    logic                     gnt_valid;
    logic [LN-1:0]            gnt_idx;
    logic [LN-1:0]            scan_idx;
    logic                     push, pop, drop;
    logic                     has_ev;
    logic [1:0]               ev_kind;
    logic                     granted;
    logic                     rpt_fire;
    logic [LN-1:0]            rpt_id;

`ifdef BTN_AUTOREPEAT_EN
    logic                     rpt_act_q, rpt_act_d;
    logic [LN-1:0]            rpt_id_q, rpt_id_d;
    logic [15:0]              rpt_cnt_q, rpt_cnt_d;

    // A new press always retargets; a release or level drop on the target cancels.
    always_comb begin
        rpt_act_d = rpt_act_q;
        rpt_id_d  = rpt_id_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (|DOWN) begin
            rpt_act_d = 1'b1;
            rpt_cnt_d = RPT_DELAY;
            for (int i = 0; i < N; i++) begin
                if (DOWN[i]) rpt_id_d = LN'(i);
            end
        end else if (rpt_act_q) begin
            if (UP[rpt_id_q] || !STATE[rpt_id_q]) begin
                rpt_act_d = 1'b0;
            end else if (rpt_cnt_q <= 16'd1) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = RPT_RATE;
            end else begin
                rpt_cnt_d = rpt_cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            rpt_act_q <= 1'b0;
            rpt_id_q  <= '0;
            rpt_cnt_q <= '0;
        end else begin
            rpt_act_q <= rpt_act_d;
            rpt_id_q  <= rpt_id_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign rpt_id = rpt_id_q;
`else
    logic unused_state;
    assign unused_state = ^STATE;
    assign rpt_fire     = 1'b0;
    assign rpt_id       = '0;
`endif

    // Round-robin scan upward from the pointer; N is a power of two so the add wraps.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = arb_ptr_q + LN'(k);
            if (!gnt_valid && slot_v_q[scan_idx] && (count_q < C_DEPTH)) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
        arb_ptr_d = gnt_valid ? gnt_idx + LN'(1) : arb_ptr_q;
    end

    always_comb begin
        slot_v_d    = slot_v_q;
        slot_kind_d = slot_kind_q;
        drop        = 1'b0;
        has_ev      = 1'b0;
        ev_kind     = KIND_DOWN;
        granted     = 1'b0;
        for (int i = 0; i < N; i++) begin
            granted = gnt_valid && (gnt_idx == LN'(i));
            has_ev  = 1'b0;
            ev_kind = KIND_DOWN;
            if (granted) slot_v_d[i] = 1'b0;
            if (UP[i]) begin
                has_ev  = 1'b1;
                ev_kind = KIND_UP;
                if (DOWN[i]) drop = 1'b1;
            end else if (DOWN[i]) begin
                has_ev  = 1'b1;
            end else if (rpt_fire && (rpt_id == LN'(i))) begin
                has_ev  = 1'b1;
                ev_kind = KIND_RPT;
            end
            if (has_ev) begin
                if (slot_v_q[i] && !granted) begin
                    drop = 1'b1;
                end else begin
                    slot_v_d[i]    = 1'b1;
                    slot_kind_d[i] = ev_kind;
                end
            end
        end
    end

    assign push    = gnt_valid;
    assign pop     = ev_valid_q & EV_ACK;
    assign count_d = count_q + {{LD{1'b0}}, push} - {{LD{1'b0}}, pop};
    assign ovf_d   = drop ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            slot_v_q    <= '0;
            slot_kind_q <= '0;
            arb_ptr_q   <= '0;
            fifo_kind_q <= '0;
            fifo_id_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ev_valid_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_kind_q <= slot_kind_d;
            arb_ptr_q   <= arb_ptr_d;
            count_q     <= count_d;
            ev_valid_q  <= (count_d != '0);
            ovf_q       <= ovf_d;
            if (push) begin
                fifo_kind_q[wr_ptr_q] <= slot_kind_q[gnt_idx];
                fifo_id_q[wr_ptr_q]   <= gnt_idx;
                wr_ptr_q              <= wr_ptr_q + LD'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + LD'(1);
        end
    end

    assign EV_VALID = ev_valid_q;
    assign EV_KIND  = fifo_kind_q[rd_ptr_q];
    assign EV_ID    = fifo_id_q[rd_ptr_q];
    assign OVF      = ovf_q;
    assign COUNT    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_event_scheduler
// Brief   : Scoreboard bench for button_event_scheduler (N=4, DEPTH=4).
// Rev     : 1.0
// ============================================================================
module tb_button_event_scheduler;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] k;
        logic [1:0] id;
        int         t;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic [3:0] DOWN, UP, STATE;
    logic       EV_VALID;
    logic [1:0] EV_KIND;
    logic [1:0] EV_ID;
    logic       EV_ACK;
    logic       OVF;
    logic       OVF_CLR;
    logic [2:0] COUNT;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   p;

    button_event_scheduler #(
        .N(N), .DEPTH(DEPTH), .RPT_DELAY(16'd10), .RPT_RATE(16'd4)
    ) dut (
        .CLK(CLK), .nRESET(nRESET), .DOWN(DOWN), .UP(UP), .STATE(STATE),
        .EV_VALID(EV_VALID), .EV_KIND(EV_KIND), .EV_ID(EV_ID), .EV_ACK(EV_ACK),
        .OVF(OVF), .OVF_CLR(OVF_CLR), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [1:0] id, input int t = -1);
        exp_t e;
        e.k = k; e.id = id; e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] d, input logic [3:0] u);
        DOWN = d; UP = u;
        tick(1);
        DOWN = '0; UP = '0;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        DOWN = '0; UP = '0; STATE = '0; EV_ACK = 1'b0; OVF_CLR = 1'b0;
        exp_q.delete();
        tick(2);
        nRESET = 1'b1;
        tick(1);
    endtask

    task automatic drain();
        EV_ACK = 1'b1;
        for (int i = 0; i < 40 && COUNT != 0; i++) tick(1);
        EV_ACK = 1'b0;
        tick(1);
        check("drain_count", COUNT, 0);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: every pop the DUT will take on the next edge is compared here.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (nRESET && EV_VALID && EV_ACK) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {EV_KIND, EV_ID}, 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("ev_kind", EV_KIND, e.k);
                check("ev_id", EV_ID, e.id);
                if (e.t >= 0) check("ev_time", cyc, e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0;
        DOWN = '0; UP = '0; STATE = '0; EV_ACK = 1'b0; OVF_CLR = 1'b0;
        #1;
        check("rst_ev_valid", EV_VALID, 0);
        check("rst_ev_kind", EV_KIND, 0);
        check("rst_ev_id", EV_ID, 0);
        check("rst_count", COUNT, 0);
        check("rst_ovf", OVF, 0);

        // Single press: one edge into the slot, one more into the FIFO.
        do_reset();
        push_exp(2'b00, 2'd2);
        pulse(4'b0100, 4'b0000);
        check("lat_not_yet_valid", EV_VALID, 0);
        tick(1);
        check("lat_valid", EV_VALID, 1);
        check("lat_kind", EV_KIND, 0);
        check("lat_id", EV_ID, 2);
        check("lat_count", COUNT, 1);
        EV_ACK = 1'b1;
        tick(1);
        EV_ACK = 1'b0;
        check("ack_count", COUNT, 0);
        EV_ACK = 1'b1;
        tick(2);
        EV_ACK = 1'b0;
        check("ack_empty_ignored", COUNT, 0);
        check("single_queue_empty", exp_q.size(), 0);

        // All four at once from pointer 0, then pointer must be back at 0.
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(2'b00, 2'(i));
        pulse(4'b1111, 4'b0000);
        tick(4);
        check("rr_count_full", COUNT, 4);
        check("rr_ovf", OVF, 0);
        drain();
        push_exp(2'b00, 2'd0);
        push_exp(2'b00, 2'd3);
        pulse(4'b1001, 4'b0000);
        tick(2);
        drain();

        // DEPTH+1 events: the last stays pending until a pop frees space.
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(2'b00, 2'(i));
        push_exp(2'b01, 2'd0);
        pulse(4'b0001, 4'b0000);
        pulse(4'b0010, 4'b0000);
        pulse(4'b0100, 4'b0000);
        pulse(4'b1000, 4'b0000);
        pulse(4'b0000, 4'b0001);
        tick(3);
        check("full_count", COUNT, 4);
        check("full_ovf", OVF, 0);
        EV_ACK = 1'b1;
        tick(1);
        EV_ACK = 1'b0;
        check("full_pop_blocks_push", COUNT, 3);
        tick(1);
        check("full_pending_enters", COUNT, 4);
        drain();

        // Drops while full, OVF_CLR losing to a same-cycle drop, then clearing.
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(2'b00, 2'(i));
        push_exp(2'b00, 2'd1);
        pulse(4'b0001, 4'b0000);
        pulse(4'b0010, 4'b0000);
        pulse(4'b0100, 4'b0000);
        pulse(4'b1000, 4'b0000);
        tick(1);
        pulse(4'b0010, 4'b0000);
        check("ovf_first_accepted", OVF, 0);
        tick(1);
        pulse(4'b0010, 4'b0000);
        check("ovf_set", OVF, 1);
        check("ovf_count", COUNT, 4);
        OVF_CLR = 1'b1;
        pulse(4'b0010, 4'b0000);
        OVF_CLR = 1'b0;
        check("ovf_clr_vs_drop", OVF, 1);
        OVF_CLR = 1'b1;
        tick(1);
        OVF_CLR = 1'b0;
        check("ovf_cleared", OVF, 0);
        drain();

        // DOWN and UP together record UP and flag overflow.
        do_reset();
        push_exp(2'b01, 2'd2);
        pulse(4'b0100, 4'b0100);
        check("both_ovf", OVF, 1);
        tick(1);
        drain();

        // Strobe in the same cycle as its slot grant is accepted cleanly.
        do_reset();
        push_exp(2'b00, 2'd1);
        push_exp(2'b01, 2'd1);
        pulse(4'b0010, 4'b0000);
        pulse(4'b0000, 4'b0010);
        tick(2);
        check("same_cycle_ovf", OVF, 0);
        check("same_cycle_count", COUNT, 2);
        drain();

        // Asynchronous reset clears state without waiting for an edge.
        do_reset();
        pulse(4'b1111, 4'b0000);
        tick(5);
        check("pre_async_count", COUNT, 4);
        #2;
        nRESET = 1'b0;
        #1;
        check("async_ev_valid", EV_VALID, 0);
        check("async_count", COUNT, 0);
        check("async_id", EV_ID, 0);

        // Held button: repeats only when the auto-repeat feature is built in.
        do_reset();
        EV_ACK = 1'b1;
        p = cyc + 1;
        push_exp(2'b00, 2'd3, p + 1);
`ifdef BTN_AUTOREPEAT_EN
        for (int r = 0; r < 4; r++) push_exp(2'b10, 2'd3, p + 11 + 4 * r);
`endif
        push_exp(2'b01, 2'd3, p + 26);
        DOWN = 4'b1000;
        STATE = 4'b1000;
        tick(1);
        DOWN = '0;
        tick(24);
        STATE = '0;
        UP = 4'b1000;
        tick(1);
        UP = '0;
        tick(20);
        EV_ACK = 1'b0;
        check("hold_count", COUNT, 0);
        check("hold_queue_empty", exp_q.size(), 0);
        check("hold_ovf", OVF, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
